// File: rtl/mpc_sram_arb_if.sv
// ---------------------------------------------------------------------------
// mpc_sram_arb_if
// Requester-side bundle of the shared-SRAM arbiter. All requesters are packed
// into one set of vectors; requester i owns bit i of the per-requester vectors
// and slice [i*W +: W] of the packed address / write-data vectors.
//
//   req_valid  [NUM_REQ]             requester -> arbiter  request valid
//   req_ready  [NUM_REQ]             arbiter -> requester  grant (one-hot or 0)
//   req_we     [NUM_REQ]             requester -> arbiter  1=write, 0=read
//   req_addr   [NUM_REQ*ADDR_SIZE]   requester -> arbiter  packed addresses
//   req_wdata  [NUM_REQ*DATA_SIZE]   requester -> arbiter  packed write data
//   rsp_valid  [NUM_REQ]             arbiter -> requester  1-cycle ack pulse
//   rsp_rdata  [DATA_SIZE]           arbiter -> requester  shared read data
//
// master: the requester side.  slave: the arbiter side.
// ---------------------------------------------------------------------------
interface mpc_sram_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*DATA_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [DATA_SIZE-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mpc_sram_arb.sv
// ---------------------------------------------------------------------------
// mpc_sram_arb
// Round-robin arbiter sharing one single-port 1RW SRAM (registered read,
// read-before-write) between NUM_REQ requesters. One request is granted per
// cycle; the granted requester receives a one-cycle rsp_valid pulse exactly
// one cycle after its valid&ready handshake, with rsp_rdata passed straight
// through from the SRAM.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          requester bundle (mpc_sram_arb_if.slave); its parameters must
//                match this module's parameters
//   sram_cs      SRAM chip select (any request pending)
//   sram_we      SRAM write enable (winner's req_we)
//   sram_addr    SRAM address (winner's address, 0 when idle)
//   sram_wdata   SRAM write data (winner's data, 0 when idle)
//   sram_rdata   SRAM registered read data, valid the cycle after sram_cs
// ---------------------------------------------------------------------------
module mpc_sram_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mpc_sram_arb_if.slave        bus,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // NUM_REQ in the width of the pointer+offset sum, for the modulo wrap.
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   rsp_valid_reg;

    logic [NUM_REQ-1:0]   valid_eff;
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_valid;
    logic [NUM_REQ-1:0]   grant_oh;

    logic [ADDR_SIZE-1:0] addr_sel  [NUM_REQ];
    logic [DATA_SIZE-1:0] wdata_sel [NUM_REQ];

    // Requests are masked while in reset so nothing is granted and the SRAM
    // port stays quiet.
    assign valid_eff = rst ? '0 : bus.req_valid;
    assign any_valid = |valid_eff;

    // Rotate the request vector so that index ptr lands at bit 0; the lowest
    // set bit of the rotated vector is then the round-robin winner's offset
    // from ptr. Duplicating the vector makes the rotation work for any
    // NUM_REQ, not just powers of two.
    assign valid_dbl = {valid_eff, valid_eff};
    assign valid_rot = NUM_REQ'(valid_dbl >> ptr_reg);

    always_comb begin
        win_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                win_off = IDX_W'(k);
            end
        end
    end

    // Winner index = (ptr + offset) mod NUM_REQ; both terms are < NUM_REQ so a
    // single conditional subtract suffices.
    assign win_sum = {1'b0, ptr_reg} + {1'b0, win_off};
    assign win_idx = (win_sum >= NUM_REQ_W) ? IDX_W'(win_sum - NUM_REQ_W)
                                             : win_sum[IDX_W-1:0];

    assign ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);

    // One-hot grant and AND-masked payload per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign grant_oh[gi]  = any_valid && (win_idx == IDX_W'(gi));
            assign addr_sel[gi]  = {ADDR_SIZE{grant_oh[gi]}}
                                 & bus.req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
            assign wdata_sel[gi] = {DATA_SIZE{grant_oh[gi]}}
                                 & bus.req_wdata[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // Grant is one-hot (or zero), so OR-ing the masked slices is the mux and
    // naturally yields 0 on an idle cycle.
    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sram_addr  = sram_addr  | addr_sel[k];
            sram_wdata = sram_wdata | wdata_sel[k];
        end
    end

    assign sram_cs = any_valid;
    assign sram_we = |(grant_oh & bus.req_we);

    assign bus.req_ready = grant_oh;
    // Masking with rst drops a response that would otherwise still be shown
    // during the reset cycle itself; the register is cleared at that edge.
    assign bus.rsp_valid = rst ? '0 : rsp_valid_reg;
    assign bus.rsp_rdata = sram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            rsp_valid_reg <= '0;
        end else begin
            rsp_valid_reg <= grant_oh;
            if (any_valid) begin
                ptr_reg <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_mpc_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_mpc_sram_arb
// Table-driven bench for mpc_sram_arb (NUM_REQ=4) with a behavioural
// read-before-write SRAM, a reference memory and a response scoreboard, plus
// hand-written reset and NUM_REQ=3 sequences on a second instance.
// ---------------------------------------------------------------------------
module tb_mpc_sram_arb;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- NUM_REQ = 4 instance ----------------
    mpc_sram_arb_if #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    mpc_sram_arb #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    logic [DW-1:0] mem     [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    // Single-port SRAM: registered read, old data returned on a write.
    always @(posedge clk) begin
        if (sram_cs) begin
            sram_rdata <= mem[sram_addr];
            if (sram_we) mem[sram_addr] <= sram_wdata;
        end
    end

    // ---------------- NUM_REQ = 3 instance ----------------
    mpc_sram_arb_if #(.NUM_REQ(3), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus3 ();
    logic          sram3_cs, sram3_we;
    logic [AW-1:0] sram3_addr;
    logic [DW-1:0] sram3_wdata;
    logic [DW-1:0] sram3_rdata;

    mpc_sram_arb #(.NUM_REQ(3), .ADDR_SIZE(AW), .DATA_SIZE(DW)) u3 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus3),
        .sram_cs    (sram3_cs),
        .sram_we    (sram3_we),
        .sram_addr  (sram3_addr),
        .sram_wdata (sram3_wdata),
        .sram_rdata (sram3_rdata)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NR-1:0] onehot;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit            do_rst;
        logic [NR-1:0] valid;
        logic [NR-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NR-1:0] exp_ready;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit r, input logic [NR-1:0] v,
                                input logic [NR-1:0] w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [NR-1:0] e);
        vec_t t;
        t.do_rst = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d; t.exp_ready = e;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare the registered response against the scoreboard head.
    task automatic check_rsp();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", bus.rsp_valid, e.onehot);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end else begin
            chk("rsp_idle", bus.rsp_valid, '0);
        end
    endtask

    // Called at a negedge; drives one cycle of requests, checks, advances.
    // Losing requesters carry a different address/data so a wrong payload mux
    // selection is visible on the SRAM port.
    task automatic apply(input vec_t v, input int n);
        logic [NR*AW-1:0] a_pk;
        logic [NR*DW-1:0] d_pk;
        for (int i = 0; i < NR; i++) begin
            a_pk[i*AW +: AW] = v.exp_ready[i] ? v.addr  : (v.addr ^ 10'h2A0 ^ AW'(i));
            d_pk[i*DW +: DW] = v.exp_ready[i] ? v.wdata : (v.wdata ^ 32'hFFFF0000 ^ DW'(i));
        end
        bus.req_valid = v.valid;
        bus.req_we    = v.we;
        bus.req_addr  = a_pk;
        bus.req_wdata = d_pk;
        #1;
        $display("vec %0d valid=%b ready=%b rsp=%b rdata=%h cs=%b we=%b addr=%h",
                 n, v.valid, bus.req_ready, bus.rsp_valid, bus.rsp_rdata,
                 sram_cs, sram_we, sram_addr);
        check_rsp();
        chk("req_ready", bus.req_ready, v.exp_ready);
        chk("sram_cs", sram_cs, |v.valid);
        if (|v.valid) begin
            chk("sram_we", sram_we, |(v.we & v.exp_ready));
            chk("sram_addr", sram_addr, v.addr);
            chk("sram_wdata", sram_wdata, v.wdata);
        end else begin
            chk("sram_we_idle", sram_we, 1'b0);
            chk("sram_addr_idle", sram_addr, '0);
            chk("sram_wdata_idle", sram_wdata, '0);
        end
        if (|v.exp_ready) begin
            sb.push_back('{onehot: v.exp_ready, rdata: ref_mem[v.addr]});
            if (|(v.we & v.exp_ready)) ref_mem[v.addr] = v.wdata;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        #1;
        check_rsp();
        chk("ready_in_rst", bus.req_ready, '0);
        $display("reset pulse rsp=%b", bus.rsp_valid);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = DW'(a) ^ 32'h5A5A0000;
            ref_mem[a] = DW'(a) ^ 32'h5A5A0000;
        end
        sram3_rdata = '0;

        // Table: do_rst, valid, we, addr, wdata, expected ready.
        // Single requester write then read (ptr 0 -> 2 -> 2).
        add(0, 4'b0010, 4'b0010, 10'h005, 32'hDEADBEEF, 4'b0010);
        add(0, 4'b0010, 4'b0000, 10'h005, 32'h0,        4'b0010);
        add(0, 4'b0000, 4'b0000, 10'h000, 32'h0,        4'b0000);
        add(1, 4'b0000, 4'b0000, 10'h000, 32'h0,        4'b0000);
        // All four reading continuously from ptr=0.
        add(0, 4'b1111, 4'b0000, 10'h010, 32'h0, 4'b0001);
        add(0, 4'b1111, 4'b0000, 10'h011, 32'h0, 4'b0010);
        add(0, 4'b1111, 4'b0000, 10'h012, 32'h0, 4'b0100);
        add(0, 4'b1111, 4'b0000, 10'h013, 32'h0, 4'b1000);
        add(0, 4'b1111, 4'b0000, 10'h014, 32'h0, 4'b0001);
        add(0, 4'b1111, 4'b0000, 10'h015, 32'h0, 4'b0010);
        // ptr=2 -> 3, then 1001 wraps: 3 then 0.
        add(0, 4'b0100, 4'b0000, 10'h020, 32'h0, 4'b0100);
        add(0, 4'b1001, 4'b0000, 10'h021, 32'h0, 4'b1000);
        add(0, 4'b1001, 4'b0000, 10'h022, 32'h0, 4'b0001);
        // Read-during-write on addr 7 (ptr=1).
        add(0, 4'b0001, 4'b0001, 10'h007, 32'h00000022, 4'b0001);
        add(0, 4'b0001, 4'b0001, 10'h007, 32'h00000011, 4'b0001);
        add(0, 4'b0100, 4'b0000, 10'h007, 32'h0,        4'b0100);
        // Idle holds ptr=3; then more rotation.
        add(0, 4'b0000, 4'b0000, 10'h000, 32'h0,        4'b0000);
        add(0, 4'b1001, 4'b1000, 10'h3FF, 32'hCAFEF00D, 4'b1000);
        add(0, 4'b0110, 4'b0000, 10'h3FF, 32'h0,        4'b0010);
        add(0, 4'b0110, 4'b0100, 10'h100, 32'h12345678, 4'b0100);
        // Granted read from req2 right before the mid-stream reset (ptr -> 3).
        add(0, 4'b0100, 4'b0000, 10'h100, 32'h0,        4'b0100);

        // Reset state: requests held high while in reset must not be granted.
        rst = 1'b1;
        bus.req_valid = 4'b1111; bus.req_we = 4'b1111;
        bus.req_addr = '1; bus.req_wdata = '1;
        bus3.req_valid = 3'b111; bus3.req_we = 3'b111;
        bus3.req_addr = '1; bus3.req_wdata = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, '0);
        chk("rst_cs", sram_cs, 1'b0);
        chk("rst_we", sram_we, 1'b0);
        chk("rst_rsp", bus.rsp_valid, '0);
        chk("rst_ready3", bus3.req_ready, '0);
        bus.req_valid = '0; bus.req_we = '0;
        bus3.req_valid = '0; bus3.req_we = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].do_rst) do_reset();
            else apply(tbl[n], n);
        end

        // Mid-stream reset: the req2 response is dropped, ptr returns to 0.
        rst = 1'b1;
        bus.req_valid = 4'b1001;
        bus.req_we    = 4'b1001;
        #1;
        void'(sb.pop_front());
        $display("mid reset rsp=%b ready=%b cs=%b", bus.rsp_valid, bus.req_ready, sram_cs);
        chk("mid_rst_rsp", bus.rsp_valid, '0);
        chk("mid_rst_ready", bus.req_ready, '0);
        chk("mid_rst_cs", sram_cs, 1'b0);
        chk("mid_rst_we", sram_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // req0 wins over req3 (ptr=0); SRAM still holds 0x11 at addr 7.
        apply('{do_rst: 0, valid: 4'b1001, we: 4'b0000, addr: 10'h007, wdata: 32'h0, exp_ready: 4'b0001}, 100);
        apply('{do_rst: 0, valid: 4'b1000, we: 4'b0000, addr: 10'h3FF, wdata: 32'h0, exp_ready: 4'b1000}, 101);
        apply('{do_rst: 0, valid: 4'b0000, we: 4'b0000, addr: 10'h000, wdata: 32'h0, exp_ready: 4'b0000}, 102);

        // NUM_REQ=3: req0 and req2 continuously; grants alternate 0,2.
        bus3.req_valid = 3'b101;
        bus3.req_we    = 3'b000;
        bus3.req_addr  = {10'h020, 10'h010, 10'h000};
        bus3.req_wdata = {32'h2, 32'h1, 32'h0};
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp_r;
            logic [2:0] exp_rsp;
            exp_r   = (k % 2 == 0) ? 3'b001 : 3'b100;
            exp_rsp = (k == 0) ? 3'b000 : ((k % 2 == 0) ? 3'b100 : 3'b001);
            #1;
            $display("nr3 cycle %0d ready=%b rsp=%b addr=%h", k, bus3.req_ready,
                     bus3.rsp_valid, sram3_addr);
            chk("nr3_ready", bus3.req_ready, exp_r);
            chk("nr3_rsp", bus3.rsp_valid, exp_rsp);
            chk("nr3_addr", sram3_addr, (k % 2 == 0) ? 10'h000 : 10'h020);
            chk("nr3_wdata", sram3_wdata, (k % 2 == 0) ? 32'h0 : 32'h2);
            chk("nr3_cs_we", {sram3_cs, sram3_we}, 2'b10);
            chk("nr3_rdata", bus3.rsp_rdata, '0);
            chk("nr3_ptr_range", u3.ptr_reg < 2'd3, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        bus3.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
